// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial add/subtract that reuses one full-adder slice, LSB first.
// Operands and sub are captured on start; sum, cout and ovf update at the final RUN edge.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, next;
    logic [WIDTH-1:0] op_a, op_b, acc;
    logic [CW-1:0]    cnt;
    logic             sub_r, carry_r, c_msb_in;
    logic             x, y, s, co, accept, last;

    assign x      = op_a[0];
    assign y      = op_b[0] ^ sub_r;
    assign s      = x ^ y ^ carry_r;
    assign co     = (x & y) | (x & carry_r) | (y & carry_r);
    assign accept = start && (state != RUN);
    assign last   = cnt == CW'(WIDTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    always_comb begin
        next = state;
        busy = state == RUN;
        done = state == DONE;
        case (state)
            IDLE:    next = start ? RUN : IDLE;
            RUN:     next = last ? DONE : RUN;
            default: next = start ? RUN : IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a     <= '0;
            op_b     <= '0;
            acc      <= '0;
            cnt      <= '0;
            sub_r    <= 1'b0;
            carry_r  <= 1'b0;
            c_msb_in <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else if (accept) begin
            op_a    <= a;
            op_b    <= b;
            sub_r   <= sub;
            carry_r <= sub;
            cnt     <= '0;
        end else if (state == RUN) begin
            carry_r <= co;
            acc     <= {s, acc[WIDTH-1:1]};
            op_a    <= op_a >> 1;
            op_b    <= op_b >> 1;
            cnt     <= cnt + CW'(1);
            // carry out of bit WIDTH-2 is the carry into the MSB
            if (cnt == CW'(WIDTH - 2)) c_msb_in <= co;
            if (last) begin
                sum  <= {s, acc[WIDTH-1:1]};
                cout <= co;
                ovf  <= co ^ c_msb_in;
            end
        end
    end
endmodule
